// File: rtl/bf_stdout_uart_if.sv
// Processor stdout byte stream: one byte per cycle that stdout_en is high.
// The processor drives as master; the UART consumer listens as slave.
interface bf_stdout_uart_if;
  logic [7:0] stdout_data;
  logic       stdout_en;

  modport master (output stdout_data, output stdout_en);
  modport slave  (input  stdout_data, input  stdout_en);
endinterface

// File: rtl/bf_stdout_uart.sv
// Buffers processor stdout bytes in a FIFO and sends them as 8N1 UART frames, LSB first.
// The producer has no backpressure, so a full FIFO drops the byte and raises a sticky overflow.
module bf_stdout_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bf_stdout_uart_if.slave       stdout_port,
  input  logic                  overflow_clr,
  output logic                  tx,
  output logic                  busy,
  output logic [FIFO_AW:0]      fifo_count,
  output logic                  overflow
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] COUNT_ZERO = (FIFO_AW + 1)'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [7:0]             sh_r;
  logic [CW-1:0]          baud_r;
  logic [2:0]             bit_idx_r;
  logic                   tx_r;
  logic                   busy_r;
  logic                   overflow_r;
  logic [FIFO_AW-1:0]     wr_ptr_r;
  logic [FIFO_AW-1:0]     rd_ptr_r;
  logic [FIFO_AW:0]       count_r;
  logic [7:0]             mem_r [DEPTH];

  logic                   push_s;
  logic                   drop_s;
  logic                   pop_s;
  logic                   bit_end_s;
  logic                   nonempty_s;
  logic                   frame_nxt_s;
  logic [FIFO_AW:0]       count_nxt_s;

  // FIFO handshake decode; full and empty are judged on the pre-edge count
  always_comb begin
    push_s      = stdout_port.stdout_en && (count_r != COUNT_FULL);
    drop_s      = stdout_port.stdout_en && (count_r == COUNT_FULL);
    bit_end_s   = (baud_r == BAUD_LAST);
    nonempty_s  = (count_r != COUNT_ZERO);
    case (state_r)
      IDLE:    pop_s = nonempty_s;
      STOP:    pop_s = bit_end_s && nonempty_s;
      default: pop_s = 1'b0;
    endcase
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + (FIFO_AW + 1)'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - (FIFO_AW + 1)'(1);
    end else begin
      count_nxt_s = count_r;
    end
    // A frame is in flight next cycle unless we sit in IDLE or finish STOP without a pop
    frame_nxt_s = pop_s || ((state_r != IDLE) && !((state_r == STOP) && bit_end_s));
  end

  // FIFO pointers, occupancy, sticky overflow and busy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= {FIFO_AW{1'b0}};
      rd_ptr_r   <= {FIFO_AW{1'b0}};
      count_r    <= COUNT_ZERO;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      end
      count_r <= count_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (overflow_clr) begin
        overflow_r <= 1'b0;
      end
      busy_r <= frame_nxt_s || (count_nxt_s != COUNT_ZERO);
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= stdout_port.stdout_data;
    end
  end

  // UART transmitter FSM; tx is set from the state being entered so it stays registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      sh_r      <= 8'h00;
      baud_r    <= {CW{1'b0}};
      bit_idx_r <= 3'd0;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          tx_r <= ~pop_s;
          if (pop_s) begin
            sh_r    <= mem_r[rd_ptr_r];
            baud_r  <= {CW{1'b0}};
            state_r <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            baud_r    <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            tx_r      <= sh_r[0];
            state_r   <= DATA;
          end else begin
            baud_r <= baud_r + CW'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            baud_r <= {CW{1'b0}};
            sh_r   <= {1'b0, sh_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= sh_r[1];
            end
          end else begin
            baud_r <= baud_r + CW'(1);
          end
        end
        STOP: begin
          if (bit_end_s) begin
            baud_r <= {CW{1'b0}};
            if (pop_s) begin
              sh_r    <= mem_r[rd_ptr_r];
              tx_r    <= 1'b0;
              state_r <= START;
            end else begin
              tx_r    <= 1'b1;
              state_r <= IDLE;
            end
          end else begin
            baud_r <= baud_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          baud_r  <= {CW{1'b0}};
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;

endmodule
